scan_decoder: RTL and testbench
===============================

Name: scan_decoder

Overview:
- Parametrised successor to the 2-to-4 one-hot decoder: SEL_W-bit select drives N = 2**SEL_W one-hot outputs.
- Two modes. Direct mode is a registered decode of an external select. Scan mode auto-cycles through enabled channels at a prescaled rate.
- Sits between the display/mux control logic and the board's digit-anode or channel-enable pins.
- Adds output polarity, channel masking, global blanking and tick/wrap status.

Parameters:
- SEL_W, 2, select width; number of channels N = 2**SEL_W (SEL_W >= 1).
- PRESCALE, 100000, clk cycles per scan step (PRESCALE >= 2); prescaler width is $clog2(PRESCALE).
- ACTIVE_LOW, 1, 1 = asserted channel output is 0 and inactive is 1; 0 = active-high.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- en  in  1  global enable; 0 = outputs blanked, all state held
- mode  in  1  0 = DIRECT, 1 = SCAN
- sel_in  in  SEL_W  channel select in DIRECT mode
- mask  in  N  per-channel enable; bit i = 0 means channel i is never asserted and is skipped in SCAN
- out  out  N  one-hot channel drive, polarity per ACTIVE_LOW
- idx  out  SEL_W  registered index of the current channel
- tick  out  1  one-cycle pulse on every SCAN advance
- wrap  out  1  one-cycle pulse when an advance gives new idx <= old idx

Behaviour:
- Reset (async assert, sync release):
  - idx = 0, prescaler = 0, tick = 0, wrap = 0.
  - out = all-inactive (all 1s if ACTIVE_LOW, else all 0s).
- Output rule, registered:
  - out asserts only bit idx, and only when en = 1 and mask[idx] = 1.
  - Otherwise out is all-inactive. Never more than one bit is asserted.
- DIRECT mode:
  - idx <= sel_in each cycle while en = 1, so out reflects sel_in one cycle later.
  - Prescaler is held at 0; tick and wrap stay 0.
- SCAN mode:
  - Prescaler counts 0..PRESCALE-1 while en = 1.
  - At terminal count, prescaler returns to 0 and idx advances to the next channel j with mask[j] = 1, searching idx+1, idx+2, … modulo N.
  - tick pulses for the cycle the new idx appears. wrap pulses in the same cycle if new idx <= old idx.
  - Only one channel enabled, at idx: idx is unchanged, tick = 1, wrap = 1.
  - mask all zero: idx holds, no tick, no wrap, out all-inactive; the prescaler keeps counting.
  - mask bit of the current idx cleared mid-step: out blanks immediately (next cycle); idx moves at the next terminal count.
- Mode change (mode differs from its registered previous value):
  - Prescaler clears to 0 in that cycle.
  - DIRECT->SCAN: scanning starts from the current idx.
- en = 0: prescaler, idx and mode history hold; out is all-inactive; tick = 0, wrap = 0. Scanning resumes on en = 1 with the prescaler value that was held.
- reset asserted mid-scan: the reset values above take effect immediately, without waiting for a clock edge.
- Latency:
  - DIRECT: sel_in to out = 1 cycle.
  - SCAN: a channel stays asserted for exactly PRESCALE cycles.

Decomposition:
- Package scan_decoder_pkg:
  - typedef enum logic {MODE_DIRECT, MODE_SCAN} scan_mode_t
  - function onehot(sel) returning the N-bit decode
- Sub-module next_enabled_sel: combinational, parametrised by SEL_W.
  - Inputs: idx, mask.
  - Outputs: nxt_idx, found (mask nonzero), wrapped (nxt_idx <= idx).
  - Circular priority search, unit-testable in isolation.
- Top module holds the prescaler, idx register, mode-history register, output register and polarity inversion.

Test Plan:
- Bench configuration for all scenarios: SEL_W = 2, PRESCALE = 4, ACTIVE_LOW = 1.
- Reset/DIRECT: assert reset mid-cycle -> out = 4'b1111 and idx = 0 immediately. Release with mode = 0, en = 1, mask = 4'b1111, sel_in = 2 -> next cycle out = 4'b1011, idx = 2.
- SCAN full: mode = 1, mask = 4'b1111, from idx = 0 -> idx steps 0,1,2,3,0 every 4 cycles; tick pulses each step; wrap pulses only on the 3->0 step; out = 1110, 1101, 1011, 0111.
- SCAN masked: mask = 4'b1010, start at idx = 1 -> idx alternates 1,3,1; wrap on 3->1; channels 0 and 2 never asserted.
- Single and empty mask:
  - mask = 4'b0100 -> idx stays 2, tick = 1 and wrap = 1 every 4 cycles.
  - mask = 0 -> out = 1111, no tick.
- en and mode boundaries:
  - en = 0 for 10 cycles mid-step -> out = 1111, idx and prescaler frozen; on resume the remaining step length completes correctly.
  - Toggle mode 1->0->1 -> prescaler cleared, the first SCAN step lasts a full 4 cycles.

Source files
------------

// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan_decoder channel driver.
package scan_decoder_pkg;

  typedef enum logic {MODE_DIRECT = 1'b0, MODE_SCAN = 1'b1} scan_mode_t;

  localparam int unsigned MAX_SEL_W = 8;
  localparam int unsigned MAX_N     = 2**MAX_SEL_W;

  // Full-width decode; callers keep the low N bits.
  function automatic logic [MAX_N-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
    logic [MAX_N-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/scan_decoder_next_enabled_sel.sv
// Circular priority search for the next enabled channel after idx.
module next_enabled_sel #(
  parameter int unsigned SEL_W = 2
) (
  input  logic [SEL_W-1:0]    idx,
  input  logic [2**SEL_W-1:0] mask,
  output logic [SEL_W-1:0]    nxt_idx,
  output logic                found,
  output logic                wrapped
);

  localparam int unsigned N = 2**SEL_W;

  logic [SEL_W-1:0] cand;

  // Walk from farthest (idx itself) to nearest so the nearest hit is kept.
  always_comb begin
    nxt_idx = idx;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = N; k >= 1; k--) begin
      cand = idx + SEL_W'(k);
      if (mask[cand]) begin
        nxt_idx = cand;
        found   = 1'b1;
      end
    end
    wrapped = found && (nxt_idx <= idx);
  end

endmodule

// File: rtl/scan_decoder.sv
// One-hot channel driver: registered direct decode or prescaled masked scan.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned PRESCALE   = 100000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel_in,
  input  logic [2**SEL_W-1:0] mask,
  output logic [2**SEL_W-1:0] out,
  output logic [SEL_W-1:0]    idx,
  output logic                tick,
  output logic                wrap
);

  localparam int unsigned N  = 2**SEL_W;
  localparam int unsigned PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] TERM = PW'(PRESCALE - 1);

  scan_mode_t       mode_cur;
  scan_mode_t       mode_prev;
  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_next;
  logic [SEL_W-1:0] idx_next;
  logic [SEL_W-1:0] nxt;
  logic             found;
  logic             wrapped;
  logic             tick_next;
  logic             wrap_next;
  logic [MAX_N-1:0] dec;
  logic [N-1:0]     lit;
  logic [N-1:0]     out_next;

  assign mode_cur = scan_mode_t'(mode);

  next_enabled_sel #(.SEL_W(SEL_W)) u_search (
    .idx     (idx),
    .mask    (mask),
    .nxt_idx (nxt),
    .found   (found),
    .wrapped (wrapped)
  );

  // out is decoded from the index being loaded so it lines up with idx.
  always_comb begin
    idx_next   = idx;
    presc_next = presc;
    tick_next  = 1'b0;
    wrap_next  = 1'b0;
    if (en) begin
      if (mode_cur == MODE_DIRECT) begin
        idx_next   = sel_in;
        presc_next = '0;
      end else if (mode_cur != mode_prev) begin
        presc_next = '0;
      end else if (presc == TERM) begin
        presc_next = '0;
        if (found) begin
          idx_next  = nxt;
          tick_next = 1'b1;
          wrap_next = wrapped;
        end
      end else begin
        presc_next = presc + PW'(1);
      end
    end
    dec      = onehot(MAX_SEL_W'(idx_next));
    lit      = (en && mask[idx_next]) ? dec[N-1:0] : '0;
    out_next = ACTIVE_LOW ? ~lit : lit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      presc     <= '0;
      mode_prev <= MODE_DIRECT;
      tick      <= 1'b0;
      wrap      <= 1'b0;
      out       <= ACTIVE_LOW ? '1 : '0;
    end else begin
      if (en) mode_prev <= mode_cur;
      idx   <= idx_next;
      presc <= presc_next;
      tick  <= tick_next;
      wrap  <= wrap_next;
      out   <= out_next;
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboarded random/directed bench for scan_decoder (SEL_W=2, PRESCALE=4, active-low).
module tb_scan_decoder;

  localparam int unsigned SEL_W    = 2;
  localparam int          N        = 4;
  localparam int          PRESCALE = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       mode;
  logic [1:0] sel_in;
  logic [3:0] mask;
  logic [3:0] dut_out;
  logic [1:0] dut_idx;
  logic       dut_tick;
  logic       dut_wrap;

  typedef struct {
    logic [3:0] out;
    logic [1:0] idx;
    logic       tick;
    logic       wrap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  // Reference state: current channel, cycles spent in step, last seen mode.
  int m_idx, m_cnt, m_prev;

  scan_decoder #(
    .SEL_W      (SEL_W),
    .PRESCALE   (PRESCALE),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .mode   (mode),
    .sel_in (sel_in),
    .mask   (mask),
    .out    (dut_out),
    .idx    (dut_idx),
    .tick   (dut_tick),
    .wrap   (dut_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_idx  = 0;
    m_cnt  = 0;
    m_prev = 0;
  endfunction

  task automatic model_step();
    exp_t e;
    int   c;
    e.tick = 1'b0;
    e.wrap = 1'b0;
    if (reset) begin
      model_reset();
    end else if (en) begin
      if (mode == 1'b0) begin
        m_idx = int'(sel_in);
        m_cnt = 0;
      end else if (int'(mode) != m_prev) begin
        m_cnt = 0;
      end else if (m_cnt == PRESCALE - 1) begin
        m_cnt = 0;
        for (int j = 1; j <= N; j++) begin
          c = (m_idx + j) % N;
          if (mask[c]) begin
            e.tick = 1'b1;
            e.wrap = (c <= m_idx);
            m_idx  = c;
            break;
          end
        end
      end else begin
        m_cnt++;
      end
      m_prev = int'(mode);
    end
    e.idx = 2'(m_idx);
    e.out = 4'hF;
    if (!reset && en && mask[m_idx]) e.out[m_idx] = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #2;
    end
  endtask

  // Reset asserted between edges must clear outputs without a clock.
  task automatic async_reset();
    @(posedge clk);
    model_step();
    #3;
    reset = 1'b1;
    #1;
    check("async_out",  int'(dut_out),  4'hF);
    check("async_idx",  int'(dut_idx),  0);
    check("async_tick", int'(dut_tick), 0);
    check("async_wrap", int'(dut_wrap), 0);
    model_reset();
    cyc(1);
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out",  int'(dut_out),  int'(e.out));
        check("idx",  int'(dut_idx),  int'(e.idx));
        check("tick", int'(dut_tick), int'(e.tick));
        check("wrap", int'(dut_wrap), int'(e.wrap));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: got running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    model_reset();
    reset  = 1'b1;
    en     = 1'b1;
    mode   = 1'b0;
    mask   = 4'hF;
    sel_in = 2'd0;
    cyc(2);
    reset  = 1'b0;
    sel_in = 2'd2;
    cyc(3);
    sel_in = 2'd1;
    cyc(1);
    async_reset();

    // full scan from idx 0
    sel_in = 2'd0;
    cyc(1);
    mode = 1'b1;
    cyc(20);

    // masked scan from idx 1
    mode   = 1'b0;
    sel_in = 2'd1;
    cyc(1);
    mask = 4'b1010;
    mode = 1'b1;
    cyc(20);

    mask = 4'b0100;
    cyc(20);
    mask = 4'b0000;
    cyc(12);

    // enable freeze mid-step
    mask = 4'hF;
    cyc(6);
    en = 1'b0;
    cyc(10);
    en = 1'b1;
    cyc(10);

    // mode toggle clears the prescaler
    cyc(2);
    mode = 1'b0;
    cyc(1);
    mode = 1'b1;
    cyc(10);

    // clear the live channel's mask bit mid-step
    cyc(1);
    mask = 4'hF;
    mask[m_idx] = 1'b0;
    cyc(8);

    mask = 4'hF;
    cyc(5);
    async_reset();

    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0) mask = 4'($urandom);
      sel_in = 2'($urandom);
      cyc(1);
    end

    #5;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
